// File: rtl/params_noc.sv
// Shared NoC constants and the per-VC state type used by the output-port VC tracker.
package params_noc;
  localparam int VC_Size         = 1;
  localparam int NUM_VC          = 2 ** VC_Size;
  localparam int DEF_BUFFER_SIZE = 8;
  localparam int CRED_W          = $clog2(DEF_BUFFER_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_t;
endpackage

// File: rtl/vc_credit_counter.sv
// One downstream VC: lifecycle state (IDLE/ACTIVE/DRAIN) plus its credit count.
module vc_credit_counter
  import params_noc::*;
#(
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic send,
  input  logic tail,
  input  logic credit,
  input  logic free,
  output logic eligible,
  output logic busy,
  output logic avail,
  output logic err
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

  vc_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             send_ok, credit_ok, free_ok;

  // Each event is judged against the current state; illegal ones are dropped.
  assign send_ok   = send && (state == ACTIVE) && (cnt != '0);
  assign credit_ok = credit && (cnt != FULL);
  assign free_ok   = free && (state == DRAIN);
  assign err       = (send && !send_ok) || (credit && !credit_ok) || (free && !free_ok);

  assign eligible = (state == IDLE) && (cnt == FULL);
  assign busy     = (state != IDLE);
  assign avail    = (cnt != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    if (grant) state_nxt = ACTIVE;
      ACTIVE:  if (send_ok && tail) state_nxt = DRAIN;
      DRAIN:   if (free_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (send_ok && !credit_ok) cnt_nxt = cnt - CNT_W'(1);
    else if (credit_ok && !send_ok) cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= FULL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

// File: rtl/output_vc_tracker.sv
// Output-port tracker of downstream VCs: round-robin VC grant, credit gating, error flag.
module output_vc_tracker
  import params_noc::*;
#(
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int NUM_VC      = params_noc::NUM_VC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req_i,
  output logic [VC_Size-1:0] alloc_vc_o,
  output logic               alloc_val_o,
  input  logic               flit_send_i,
  input  logic [VC_Size-1:0] flit_vc_i,
  input  logic               flit_tail_i,
  input  logic               credit_i,
  input  logic [VC_Size-1:0] credit_vc_i,
  input  logic               vc_free_i,
  input  logic [VC_Size-1:0] vc_free_id_i,
  output logic [NUM_VC-1:0]  credit_avail_o,
  output logic [NUM_VC-1:0]  vc_busy_o,
  output logic               err_o
);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  logic [NUM_VC-1:0]  elig, lerr, grant;
  logic [VC_Size-1:0] ptr, pick, idx;
  logic               found, do_grant;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_credit_counter #(
      .BUFFER_SIZE(BUFFER_SIZE),
      .CNT_W      (CNT_W)
    ) u_vc (
      .clk     (clk),
      .rst     (rst),
      .grant   (grant[v]),
      .send    (flit_send_i && (flit_vc_i == VC_Size'(v))),
      .tail    (flit_tail_i),
      .credit  (credit_i && (credit_vc_i == VC_Size'(v))),
      .free    (vc_free_i && (vc_free_id_i == VC_Size'(v))),
      .eligible(elig[v]),
      .busy    (vc_busy_o[v]),
      .avail   (credit_avail_o[v]),
      .err     (lerr[v])
    );
  end

  // Search wraps naturally because NUM_VC is a power of two.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = ptr + VC_Size'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign do_grant = alloc_req_i && found;
  assign grant    = do_grant ? (NUM_VC'(1) << pick) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      alloc_val_o <= 1'b0;
      alloc_vc_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      alloc_val_o <= do_grant;
      err_o       <= |lerr;
      if (do_grant) begin
        alloc_vc_o <= pick;
        ptr        <= pick + VC_Size'(1);
      end
    end
  end
endmodule

// File: tb/tb_output_vc_tracker.sv
// Directed scenarios plus randomized traffic checked against a rule-level reference model.
module tb_output_vc_tracker;
  localparam int B = 8;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req_i = 1'b0;
  logic [0:0] alloc_vc_o;
  logic       alloc_val_o;
  logic       flit_send_i = 1'b0;
  logic [0:0] flit_vc_i = '0;
  logic       flit_tail_i = 1'b0;
  logic       credit_i = 1'b0;
  logic [0:0] credit_vc_i = '0;
  logic       vc_free_i = 1'b0;
  logic [0:0] vc_free_id_i = '0;
  logic [1:0] credit_avail_o;
  logic [1:0] vc_busy_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = free, 1 = carrying a packet, 2 = draining.
  int st[N];
  int cr[N];
  int mptr;
  bit ev;
  int evc;
  bit eerr;

  output_vc_tracker #(.BUFFER_SIZE(B), .NUM_VC(N)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_vc_o(alloc_vc_o), .alloc_val_o(alloc_val_o),
    .flit_send_i(flit_send_i), .flit_vc_i(flit_vc_i), .flit_tail_i(flit_tail_i),
    .credit_i(credit_i), .credit_vc_i(credit_vc_i),
    .vc_free_i(vc_free_i), .vc_free_id_i(vc_free_id_i),
    .credit_avail_o(credit_avail_o), .vc_busy_o(vc_busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] expv();
    logic [1:0] b, a;
    for (int v = 0; v < N; v++) begin
      b[v] = (st[v] != 0);
      a[v] = (cr[v] != 0);
    end
    return {ev, 1'(evc), eerr, b, a};
  endfunction

  function automatic logic [6:0] obsv();
    return {alloc_val_o, alloc_vc_o, err_o, vc_busy_o, credit_avail_o};
  endfunction

  task automatic zero_inputs();
    alloc_req_i = 0; flit_send_i = 0; flit_vc_i = 0; flit_tail_i = 0;
    credit_i = 0; credit_vc_i = 0; vc_free_i = 0; vc_free_id_i = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int v = 0; v < N; v++) begin st[v] = 0; cr[v] = B; end
    mptr = 0; ev = 0; evc = 0; eerr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    zero_inputs();
  endtask

  task automatic cycle(input bit req, input bit snd, input int svc, input bit tl,
                       input bit crd, input int cvc, input bit fr, input int fid);
    int nst[N];
    int ncr[N];
    bit e;
    bit g;
    alloc_req_i = req; flit_send_i = snd; flit_vc_i = 1'(svc); flit_tail_i = tl;
    credit_i = crd; credit_vc_i = 1'(cvc); vc_free_i = fr; vc_free_id_i = 1'(fid);
    nst = st; ncr = cr; e = 0; g = 0;
    if (snd) begin
      if (st[svc] != 1 || cr[svc] == 0) e = 1;
      else begin
        ncr[svc] -= 1;
        if (tl) nst[svc] = 2;
      end
    end
    if (crd) begin
      if (cr[cvc] == B) e = 1;
      else ncr[cvc] += 1;
    end
    if (fr) begin
      if (st[fid] != 2) e = 1;
      else nst[fid] = 0;
    end
    if (req) begin
      for (int k = 0; k < N; k++) begin
        int v;
        v = (mptr + k) % N;
        if (!g && st[v] == 0 && cr[v] == B) begin
          g = 1; nst[v] = 1; evc = v;
        end
      end
      if (g) mptr = (evc + 1) % N;
    end
    @(posedge clk); #1;
    st = nst; cr = ncr; eerr = e; ev = g;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obsv() !== 7'b0_0_0_00_11) begin
      errors++;
      $display("FAIL reset_values got %b want %b", obsv(), 7'b0_0_0_00_11);
    end
  endtask

  task automatic test_grant();
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (alloc_val_o !== 1'b1 || alloc_vc_o !== 1'b0 || vc_busy_o !== 2'b01) begin
      errors++;
      $display("FAIL first_grant got val=%b vc=%b busy=%b want val=1 vc=0 busy=01",
               alloc_val_o, alloc_vc_o, vc_busy_o);
    end
    idle();
    checks++;
    if (alloc_val_o !== 1'b0 || alloc_vc_o !== 1'b0) begin
      errors++;
      $display("FAIL grant_pulse got val=%b vc=%b want val=0 vc=0", alloc_val_o, alloc_vc_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      got[i] = {alloc_val_o, alloc_vc_o};
    end
    checks++;
    if (got[0] !== 2'b10 || got[1] !== 2'b11 || got[2][1] !== 1'b0 || vc_busy_o !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back got %b %b %b busy=%b want 10 11 0x busy=11",
               got[0], got[1], got[2], vc_busy_o);
    end
    checks++;
    if (alloc_vc_o !== 1'b1) begin
      errors++;
      $display("FAIL vc_hold got %b want 1", alloc_vc_o);
    end
  endtask

  task automatic test_credit_exhaust();
    bit early_err = 0;
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < B; i++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      if (err_o !== 1'b0) early_err = 1;
    end
    checks++;
    if (credit_avail_o !== 2'b10 || early_err) begin
      errors++;
      $display("FAIL credit_exhaust got avail=%b err_seen=%0d want avail=10 err_seen=0",
               credit_avail_o, early_err);
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (err_o !== 1'b1 || credit_avail_o !== 2'b10) begin
      errors++;
      $display("FAIL send_no_credit got err=%b avail=%b want err=1 avail=10", err_o, credit_avail_o);
    end
    idle();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got %b want 0", err_o);
    end
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (credit_avail_o !== 2'b11 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL credit_after_zero got avail=%b err=%b want avail=11 err=0", credit_avail_o, err_o);
    end
  endtask

  task automatic test_same_cycle();
    bit seen_err = 0;
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0, 0, 0);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL send_credit_same got err=%b want 0", err_o);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      if (err_o !== 1'b0) seen_err = 1;
    end
    checks++;
    if (seen_err || credit_avail_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL count_held_at_5 got err_seen=%0d avail0=%b want err_seen=0 avail0=0",
               seen_err, credit_avail_o[0]);
    end
  endtask

  task automatic test_headtail();
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0, 0, 0);
    checks++;
    if (vc_busy_o !== 2'b11 || err_o !== 1'b0 || credit_avail_o !== 2'b11) begin
      errors++;
      $display("FAIL headtail_send got busy=%b err=%b avail=%b want busy=11 err=0 avail=11",
               vc_busy_o, err_o, credit_avail_o);
    end
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (vc_busy_o !== 2'b01 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL headtail_free got busy=%b err=%b want busy=01 err=0", vc_busy_o, err_o);
    end
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (alloc_val_o !== 1'b1 || alloc_vc_o !== 1'b1 || vc_busy_o !== 2'b11) begin
      errors++;
      $display("FAIL regrant_vc1 got val=%b vc=%b busy=%b want val=1 vc=1 busy=11",
               alloc_val_o, alloc_vc_o, vc_busy_o);
    end
  endtask

  task automatic test_free_conflicts();
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL free_idle got err=%b want 1", err_o);
    end
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 1, 0);
    checks++;
    if (err_o !== 1'b1 || vc_busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL tail_free_same got err=%b busy0=%b want err=1 busy0=1", err_o, vc_busy_o[0]);
    end
    // VC1 busy as well so only VC0 could be picked once freed.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (alloc_val_o !== 1'b0 || vc_busy_o !== 2'b10) begin
      errors++;
      $display("FAIL free_req_same got val=%b busy=%b want val=0 busy=10", alloc_val_o, vc_busy_o);
    end
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (alloc_val_o !== 1'b1 || alloc_vc_o !== 1'b0) begin
      errors++;
      $display("FAIL grant_after_free got val=%b vc=%b want val=1 vc=0", alloc_val_o, alloc_vc_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    alloc_req_i = 1; flit_send_i = 1; flit_vc_i = 1; credit_i = 1; vc_free_i = 1;
    do_reset();
    checks++;
    if (obsv() !== 7'b0_0_0_00_11) begin
      errors++;
      $display("FAIL reset_mid_packet got %b want %b", obsv(), 7'b0_0_0_00_11);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit req, snd, tl, crd, fr;
      int svc, cvc, fid;
      req = ($urandom_range(0, 3) == 0);
      snd = ($urandom_range(0, 1) == 0);
      svc = $urandom_range(0, N - 1);
      tl  = ($urandom_range(0, 5) == 0);
      crd = ($urandom_range(0, 2) == 0);
      cvc = $urandom_range(0, N - 1);
      if (crd && cr[cvc] == B && $urandom_range(0, 3) != 0) crd = 0;
      fid = $urandom_range(0, N - 1);
      fr  = (st[fid] == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) begin
        do_reset();
      end else begin
        cycle(req, snd, svc, tl, crd, cvc, fr, fid);
      end
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL random_cycle_%0d got %b want %b", n, obsv(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_back_to_back();
    test_credit_exhaust();
    test_same_cycle();
    test_headtail();
    test_free_conflicts();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
